ps2_scan_ctrl: RTL and testbench
================================

# ps2_scan_ctrl

Controller that sequences the PS/2 byte receiver and turns its raw bytes into key events. It watches the receiver's frame-complete flag and the device clock, and decodes the E0/F0 prefixes into one event per key. Events are buffered in a small FIFO. The block throttles the keyboard by inhibiting the PS/2 clock when the FIFO nears full, and resynchronises the receiver after a stalled frame. It sits between the receiver and the host-side key consumer.

## Interface
- FIFO_DEPTH, 4, event FIFO entries (power of two, ≥4)
- TIMEOUT_CYCLES, 50000, clk cycles without a PS/2 clock falling edge before an open frame is aborted (1 ms at 50 MHz)

- clk  in  1  system clock; all logic on rising edge
- rst_n  in  1  synchronous, active-low reset
- ps2_clk_in  in  1  raw PS/2 device clock (asynchronous)
- rx_done  in  1  receiver frame-complete level (asynchronous; high = valid frame, low while next frame runs)
- rx_data  in  8  receiver data byte, stable while rx_done high
- rx_rst  out  1  one-cycle pulse: force receiver back to its idle state
- ps2_clk_inhibit  out  1  drive PS/2 clock line low (open-drain control)
- ev_valid  out  1  FIFO head holds an event
- ev_ready  in  1  consumer accepts head when ev_valid & ev_ready
- ev_code  out  8  scan code of head event
- ev_break  out  1  head event is a release
- ev_ext  out  1  head event carried E0 prefix
- err_proto  out  1  one-cycle pulse: illegal prefix sequence or error byte
- err_timeout  out  1  one-cycle pulse: frame aborted by watchdog
- err_overflow  out  1  sticky: event dropped on full FIFO; cleared only by reset

## Operation
- ps2_clk_in and rx_done pass through 2-FF synchronisers; edges are detected on the synchronised signals.
- A byte is accepted on a synchronised rx_done rising edge; rx_data is sampled in the same cycle.
- Prefix FSM states: IDLE, E0, F0, E0F0.
  - IDLE: byte E0 → E0; F0 → F0; 00 or FF → err_proto, stay IDLE; any other byte → push {code, brk=0, ext=0}.
  - E0: F0 → E0F0; E0 → err_proto, stay E0; 00/FF → err_proto, IDLE; other → push {code,0,1}, IDLE.
  - F0: F0 → err_proto, stay; E0 → err_proto, go to E0; 00/FF → err_proto, IDLE; other → push {code,1,0}, IDLE.
  - E0F0: F0 → err_proto, stay; E0 → err_proto, go to E0; 00/FF → err_proto, IDLE; other → push {code,1,1}, IDLE.
- Frame tracking:
  - in_frame sets on a synchronised ps2_clk falling edge while rx_done is low.
  - in_frame clears on an rx_done rising edge.
  - A watchdog counter clears on each ps2_clk falling edge and counts while in_frame.
  - When the counter reaches TIMEOUT_CYCLES: rx_rst=1 and err_timeout=1 for one cycle, in_frame clears, counter clears, FSM → IDLE.
- FIFO:
  - ev_valid = not empty; head fields are driven from the read pointer.
  - Pop when ev_valid & ev_ready.
  - Push when full and no pop in the same cycle: the event is dropped and err_overflow sets.
  - Push and pop in the same cycle while full: both take effect, no overflow.
- Flow control:
  - ps2_clk_inhibit asserts when free slots ≤1 and in_frame=0; an open frame is never cut.
  - It deasserts when free slots ≥2.
  - While inhibit is high, the watchdog is held at 0.

## Timing
- Reset: all outputs 0, FIFO empty, FSM IDLE, counter 0, in_frame 0, synchroniser flops 0.
- rx_done rises before clk edge N → byte accepted at edge N+2 → ev_valid high after edge N+3 (FIFO empty case).
- Pop: head advances on the edge where ev_valid & ev_ready; the next entry is visible in the following cycle.
- err_proto and err_timeout are registered single-cycle pulses, asserted the cycle after the triggering edge.
- If rst_n is low on any edge, every register takes its reset value, including mid-prefix and mid-frame. rx_rst is not pulsed by reset.
- Watchdog: abort pulse occurs exactly TIMEOUT_CYCLES clk cycles after the last synchronised falling edge.
- Inhibit changes at most once per cycle; it is registered, with 1-cycle latency from the FIFO count change.

## Test plan
- rx_done edge with byte 1C → one event ev_code=1C, ev_break=0, ev_ext=0; ev_valid 3 cycles after rx_done rises.
- Bytes E0, F0, 75 → exactly one event: 75, break=1, ext=1; no events for the prefixes.
- ev_ready=0, five make codes 15,1D,24,2D,35 with FIFO_DEPTH=4:
  - inhibit rises once 3 entries are held and no frame is open;
  - 35 is dropped and err_overflow=1;
  - draining returns 15,1D,24,2D in order, and inhibit falls at 2 entries.
- Five ps2_clk falling edges, then the clock stops, TIMEOUT_CYCLES=100 → rx_rst and err_timeout pulse 100 cycles after the last edge; the FSM is IDLE.
- F0 received, then rst_n low 1 cycle, then 1C → event 1C with break=0.
- Bytes F0, F0, 00 → two err_proto pulses, no events, FSM IDLE; a following 1C gives a make event.

Source files
------------

// File: rtl/ps2_scan_ctrl.sv
// ps2_scan_ctrl: sequences a PS/2 byte receiver, decodes E0/F0 prefixes into
// key events, buffers them in a small FIFO, throttles the keyboard through
// clock inhibit and aborts stalled frames with a watchdog.
module ps2_scan_ctrl #(
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ps2_clk_in,
  input  logic       rx_done,
  input  logic [7:0] rx_data,
  output logic       rx_rst,
  output logic       ps2_clk_inhibit,
  output logic       ev_valid,
  input  logic       ev_ready,
  output logic [7:0] ev_code,
  output logic       ev_break,
  output logic       ev_ext,
  output logic       err_proto,
  output logic       err_timeout,
  output logic       err_overflow
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int WD_W  = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_E0   = 2'd1,
    ST_F0   = 2'd2,
    ST_E0F0 = 2'd3
  } state_t;

  state_t state_q, state_d;

  // bit0: metastability stage, bit1: synchronised level, bit2: previous level
  logic [2:0] ps2_sync_q, ps2_sync_d;
  logic [2:0] rxd_sync_q, rxd_sync_d;

  logic             push_q, push_d;
  logic [9:0]       push_ev_q, push_ev_d;   // {brk, ext, code}
  logic             err_proto_q, err_proto_d;
  logic             in_frame_q, in_frame_d;
  logic [WD_W-1:0]  wd_q, wd_d;
  logic             rx_rst_q, rx_rst_d;
  logic             err_timeout_q, err_timeout_d;
  logic             err_overflow_q, err_overflow_d;
  logic             inhibit_q, inhibit_d;
  logic [9:0]       mem_q [FIFO_DEPTH];
  logic [9:0]       mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic ps2_fall, rx_rise, rx_done_s, timeout_hit;
  logic is_e0, is_f0, is_bad;
  logic full, do_pop, do_wr;
  logic [9:0] head;

  assign ps2_fall  = ~ps2_sync_q[1] & ps2_sync_q[2];
  assign rx_rise   = rxd_sync_q[1] & ~rxd_sync_q[2];
  assign rx_done_s = rxd_sync_q[1];

  assign is_e0  = (rx_data == 8'hE0);
  assign is_f0  = (rx_data == 8'hF0);
  assign is_bad = (rx_data == 8'h00) || (rx_data == 8'hFF);

  // A stalled frame only times out if nothing else touched it this cycle.
  assign timeout_hit = in_frame_q & ~inhibit_q & ~ps2_fall & ~rx_rise &
                       (wd_q == WD_W'(TIMEOUT_CYCLES - 1));

  assign full     = (count_q == CNT_W'(FIFO_DEPTH));
  assign ev_valid = (count_q != '0);
  assign do_pop   = ev_valid & ev_ready;
  assign do_wr    = push_q & (~full | do_pop);
  assign head     = mem_q[rd_ptr_q];

  assign ev_code         = ev_valid ? head[7:0] : 8'h00;
  assign ev_break        = ev_valid & head[9];
  assign ev_ext          = ev_valid & head[8];
  assign rx_rst          = rx_rst_q;
  assign err_timeout     = err_timeout_q;
  assign err_proto       = err_proto_q;
  assign err_overflow    = err_overflow_q;
  assign ps2_clk_inhibit = inhibit_q;

  // Synchroniser shift chains for the two asynchronous inputs.
  always_comb begin
    ps2_sync_d = {ps2_sync_q[1:0], ps2_clk_in};
    rxd_sync_d = {rxd_sync_q[1:0], rx_done};
  end

  // Prefix decoder: next state, event push and protocol error per accepted byte.
  always_comb begin
    state_d     = state_q;
    push_d      = 1'b0;
    push_ev_d   = push_ev_q;
    err_proto_d = 1'b0;
    if (timeout_hit) begin
      state_d = ST_IDLE;
    end else if (rx_rise) begin
      case (state_q)
        ST_IDLE: begin
          if (is_e0)       state_d = ST_E0;
          else if (is_f0)  state_d = ST_F0;
          else if (is_bad) err_proto_d = 1'b1;
          else begin
            push_d    = 1'b1;
            push_ev_d = {2'b00, rx_data};
          end
        end
        ST_E0: begin
          if (is_f0)       state_d = ST_E0F0;
          else if (is_e0)  err_proto_d = 1'b1;
          else if (is_bad) begin
            err_proto_d = 1'b1;
            state_d     = ST_IDLE;
          end else begin
            push_d    = 1'b1;
            push_ev_d = {2'b01, rx_data};
            state_d   = ST_IDLE;
          end
        end
        ST_F0, ST_E0F0: begin
          if (is_f0) err_proto_d = 1'b1;
          else if (is_e0) begin
            err_proto_d = 1'b1;
            state_d     = ST_E0;
          end else if (is_bad) begin
            err_proto_d = 1'b1;
            state_d     = ST_IDLE;
          end else begin
            push_d    = 1'b1;
            push_ev_d = {1'b1, (state_q == ST_E0F0), rx_data};
            state_d   = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Frame tracking and watchdog; inhibit holds the watchdog at zero.
  always_comb begin
    in_frame_d    = in_frame_q;
    wd_d          = wd_q;
    rx_rst_d      = 1'b0;
    err_timeout_d = 1'b0;
    if (rx_rise)                     in_frame_d = 1'b0;
    else if (ps2_fall && !rx_done_s) in_frame_d = 1'b1;
    if (inhibit_q || ps2_fall) begin
      wd_d = '0;
    end else if (timeout_hit) begin
      wd_d          = '0;
      in_frame_d    = 1'b0;
      rx_rst_d      = 1'b1;
      err_timeout_d = 1'b1;
    end else if (in_frame_q) begin
      wd_d = wd_q + WD_W'(1);
    end else begin
      wd_d = '0;
    end
  end

  // Event FIFO bookkeeping, sticky overflow and registered clock inhibit.
  always_comb begin
    mem_d          = mem_q;
    wr_ptr_d       = wr_ptr_q;
    rd_ptr_d       = rd_ptr_q;
    count_d        = count_q;
    err_overflow_d = err_overflow_q | (push_q & full & ~do_pop);
    inhibit_d      = inhibit_q;
    if (do_wr) begin
      mem_d[wr_ptr_q] = push_ev_q;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (do_pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
    if (do_wr && !do_pop)      count_d = count_q + CNT_W'(1);
    else if (!do_wr && do_pop) count_d = count_q - CNT_W'(1);
    // An open frame is never cut: assertion waits until in_frame drops.
    if ((count_q >= CNT_W'(FIFO_DEPTH - 1)) && !in_frame_q) inhibit_d = 1'b1;
    else if (count_q <= CNT_W'(FIFO_DEPTH - 2))             inhibit_d = 1'b0;
  end

  // Prefix FSM state register.
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // All remaining registers, cleared by synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ps2_sync_q     <= '0;
      rxd_sync_q     <= '0;
      push_q         <= 1'b0;
      push_ev_q      <= '0;
      err_proto_q    <= 1'b0;
      in_frame_q     <= 1'b0;
      wd_q           <= '0;
      rx_rst_q       <= 1'b0;
      err_timeout_q  <= 1'b0;
      err_overflow_q <= 1'b0;
      inhibit_q      <= 1'b0;
      mem_q          <= '{default: '0};
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      count_q        <= '0;
    end else begin
      ps2_sync_q     <= ps2_sync_d;
      rxd_sync_q     <= rxd_sync_d;
      push_q         <= push_d;
      push_ev_q      <= push_ev_d;
      err_proto_q    <= err_proto_d;
      in_frame_q     <= in_frame_d;
      wd_q           <= wd_d;
      rx_rst_q       <= rx_rst_d;
      err_timeout_q  <= err_timeout_d;
      err_overflow_q <= err_overflow_d;
      inhibit_q      <= inhibit_d;
      mem_q          <= mem_d;
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      count_q        <= count_d;
    end
  end

endmodule

// File: tb/tb_ps2_scan_ctrl.sv
// Self-checking bench for ps2_scan_ctrl: a prefix-rule reference model fills
// an expected-event queue; a forked monitor pops and compares every transfer.
module tb_ps2_scan_ctrl;

  localparam int DEPTH = 4;
  localparam int TMO   = 100;

  logic       clk = 1'b0;
  logic       rst_n, ps2_clk_in, rx_done, ev_ready;
  logic [7:0] rx_data;
  logic       rx_rst, ps2_clk_inhibit, ev_valid, ev_break, ev_ext;
  logic [7:0] ev_code;
  logic       err_proto, err_timeout, err_overflow;

  ps2_scan_ctrl #(.FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .ps2_clk_in(ps2_clk_in), .rx_done(rx_done),
    .rx_data(rx_data), .rx_rst(rx_rst), .ps2_clk_inhibit(ps2_clk_inhibit),
    .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_code(ev_code),
    .ev_break(ev_break), .ev_ext(ev_ext), .err_proto(err_proto),
    .err_timeout(err_timeout), .err_overflow(err_overflow)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  logic [9:0] exp_q[$];   // {code, brk, ext}
  logic pend_brk = 1'b0;
  logic pend_ext = 1'b0;
  logic ov_exp   = 1'b0;
  int proto_exp = 0, proto_seen = 0;
  int tmo_seen = 0, rxrst_seen = 0;
  logic rand_ready = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference model: prefixes are remembered as pending flags; a plain code
  // byte consumes them and yields one event.
  task automatic model_byte(input logic [7:0] b);
    if (b == 8'h00 || b == 8'hFF) begin
      proto_exp++;
      pend_brk = 1'b0;
      pend_ext = 1'b0;
    end else if (b == 8'hE0) begin
      if (pend_brk || pend_ext) proto_exp++;
      pend_ext = 1'b1;
      pend_brk = 1'b0;
    end else if (b == 8'hF0) begin
      if (pend_brk) proto_exp++;
      pend_brk = 1'b1;
    end else begin
      if (exp_q.size() >= DEPTH) ov_exp = 1'b1;
      else exp_q.push_back({b, pend_brk, pend_ext});
      pend_brk = 1'b0;
      pend_ext = 1'b0;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_ready) ev_ready = ($urandom_range(0, 1) == 1);
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data = b;
    tick();
    rx_done = 1'b1;
    model_byte(b);
    repeat (4) tick();
    rx_done = 1'b0;
    repeat (4) tick();
  endtask

  task automatic wait_drain(input string name);
    int k;
    k = 0;
    ev_ready = 1'b1;
    while ((exp_q.size() != 0 || ev_valid) && k < 300) begin
      tick();
      k++;
    end
    check({name, "_queue_empty"}, 32'(exp_q.size()), 32'd0);
    check({name, "_ev_valid_low"}, 32'(ev_valid), 32'd0);
  endtask

  task automatic pop_one();
    ev_ready = 1'b1;
    tick();
    ev_ready = 1'b0;
    repeat (2) tick();
  endtask

  task automatic monitor();
    logic [9:0] e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (ev_valid && ev_ready) begin
          if (exp_q.size() == 0) begin
            check("event_without_expectation", 32'(exp_q.size()), 32'd1);
          end else begin
            e = exp_q.pop_front();
            check("event_fields", 32'({ev_code, ev_break, ev_ext}), 32'(e));
          end
        end
        if (err_proto)   proto_seen++;
        if (err_timeout) tmo_seen++;
        if (rx_rst)      rxrst_seen++;
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_time_limit: simulation did not finish");
    $fatal(1, "time limit");
  end

  initial begin
    logic early;
    logic [7:0] b;
    int r;
    fork
      monitor();
    join_none

    rst_n = 1'b0; ps2_clk_in = 1'b1; rx_done = 1'b0; rx_data = 8'h00; ev_ready = 1'b0;
    repeat (3) tick();
    check("rst_outputs_in_reset",
          32'({rx_rst, ps2_clk_inhibit, ev_valid, err_proto, err_timeout, err_overflow}), 32'd0);
    check("rst_ev_fields", 32'({ev_code, ev_break, ev_ext}), 32'd0);
    rst_n = 1'b1;
    repeat (2) tick();
    check("after_rst_outputs",
          32'({rx_rst, ps2_clk_inhibit, ev_valid, err_proto, err_timeout, err_overflow}), 32'd0);

    // Latency of a single make code with the FIFO empty.
    rx_data = 8'h1C;
    rx_done = 1'b1;
    model_byte(8'h1C);
    repeat (3) tick();
    check("latency_not_yet_valid", 32'(ev_valid), 32'd0);
    tick();
    check("latency_valid_at_3", 32'(ev_valid), 32'd1);
    repeat (3) tick();
    rx_done = 1'b0;
    repeat (4) tick();
    wait_drain("make_1c");

    // Extended release: one event only.
    send_byte(8'hE0);
    send_byte(8'hF0);
    send_byte(8'h75);
    wait_drain("ext_break_75");
    check("ext_break_proto", 32'(proto_seen), 32'(proto_exp));

    // Fill, overflow and flow control with the consumer stalled.
    ev_ready = 1'b0;
    send_byte(8'h15);
    send_byte(8'h1D);
    check("inhibit_low_at_2", 32'(ps2_clk_inhibit), 32'd0);
    send_byte(8'h24);
    check("inhibit_high_at_3", 32'(ps2_clk_inhibit), 32'd1);
    send_byte(8'h2D);
    check("no_overflow_at_4", 32'(err_overflow), 32'd0);
    send_byte(8'h35);
    check("overflow_sticky", 32'(err_overflow), 32'(ov_exp));
    check("inhibit_high_full", 32'(ps2_clk_inhibit), 32'd1);
    pop_one();
    check("inhibit_high_at_3_drain", 32'(ps2_clk_inhibit), 32'd1);
    pop_one();
    check("inhibit_low_at_2_drain", 32'(ps2_clk_inhibit), 32'd0);
    wait_drain("overflow_drain");

    // Watchdog: pending F0, five clock falls, then the clock stops.
    send_byte(8'hF0);
    for (int i = 0; i < 5; i++) begin
      ps2_clk_in = 1'b0;
      if (i < 4) begin
        repeat (4) tick();
        ps2_clk_in = 1'b1;
        repeat (4) tick();
      end
    end
    early = 1'b0;
    for (int j = 1; j <= 105; j++) begin
      tick();
      if (j == 3) ps2_clk_in = 1'b1;
      if (j == TMO + 3) begin
        check("timeout_pulse", 32'(err_timeout), 32'd1);
        check("rx_rst_pulse", 32'(rx_rst), 32'd1);
      end else if (err_timeout || rx_rst) begin
        early = 1'b1;
      end
    end
    check("timeout_only_at_exact_cycle", 32'(early), 32'd0);
    pend_brk = 1'b0;
    pend_ext = 1'b0;
    send_byte(8'h1C);
    wait_drain("after_timeout");
    check("timeout_count", 32'(tmo_seen), 32'd1);
    check("rx_rst_count", 32'(rxrst_seen), 32'd1);

    // Reset mid-prefix forgets the F0 and clears the sticky overflow.
    send_byte(8'hF0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    pend_brk = 1'b0;
    pend_ext = 1'b0;
    ov_exp = 1'b0;
    tick();
    check("overflow_cleared_by_reset", 32'(err_overflow), 32'(ov_exp));
    send_byte(8'h1C);
    wait_drain("after_reset");

    // Illegal prefix sequences.
    send_byte(8'hF0);
    send_byte(8'hF0);
    send_byte(8'h00);
    check("proto_f0f000", 32'(proto_seen), 32'(proto_exp));
    send_byte(8'h1C);
    wait_drain("after_proto");

    // Randomised byte stream with a randomly stalling consumer.
    rand_ready = 1'b1;
    for (int n = 0; n < 80; n++) begin
      r = $urandom_range(0, 99);
      if (r < 15)      b = 8'hE0;
      else if (r < 30) b = 8'hF0;
      else if (r < 34) b = (r < 32) ? 8'h00 : 8'hFF;
      else begin
        b = 8'($urandom_range(1, 254));
        while (b == 8'hE0 || b == 8'hF0) b = 8'($urandom_range(1, 254));
      end
      send_byte(b);
    end
    rand_ready = 1'b0;
    wait_drain("random");
    check("random_proto", 32'(proto_seen), 32'(proto_exp));
    check("random_no_overflow", 32'(err_overflow), 32'(ov_exp));
    check("final_timeout_count", 32'(tmo_seen), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
